spi_eeprom_reader: RTL

SPI master receive engine that reads a burst of bytes from the M25AA160C serial EEPROM. It issues the READ instruction and a 16-bit address on MOSI, then clocks in the requested number of bytes from MISO. Each byte is delivered on a valid/ready byte stream. It is the MISO-side counterpart of the SPI byte writer and feeds the AXI-Lite-to-SPI peripheral's read datapath.

---
 rtl/spi_reader_pkg.sv | 22 ++
 rtl/spi_clk_gen.sv | 41 ++++
 rtl/spi_eeprom_reader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_reader_pkg.sv
// Shared types and constants for the SPI EEPROM read engine.
package spi_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    HEADER,
    DATA,
    STALL,
    CS_HOLD,
    DRAIN
  } state_t;

  localparam int HDR_BITS  = 24;
  localparam int BYTE_BITS = 8;

  // A Len of zero requests a full 256-byte burst.
  function automatic logic [8:0] burst_len(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter producing SCK rise/fall strobes; the phase alternates
// on every terminal count, starting with a rise after a clear.
module spi_clk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          phase;
  logic          tick;

  assign tick     = en && (cnt == CW'(CLK_DIV - 1));
  assign sck_rise = tick && !phase;
  assign sck_fall = tick && phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (tick) begin
        cnt   <= '0;
        phase <= !phase;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_eeprom_reader.sv
// SPI mode-0 burst reader: sends READ + 16-bit address, then streams received
// bytes through a single-entry valid/ready output register.
module spi_eeprom_reader
  import spi_reader_pkg::*;
#(
  parameter int         CLK_DIV  = 10,
  parameter logic [7:0] READ_CMD = 8'h03
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        Start,
  input  logic [15:0] Addr,
  input  logic [7:0]  Len,
  output logic        Busy,
  output logic [7:0]  RD_Data,
  output logic        RD_Valid,
  input  logic        RD_Ready,
  output logic        SPI_SCK,
  output logic        SPI_CS_N,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  state_t      state;
  logic        pending;
  logic        busy;
  logic        cs_n;
  logic        sck;
  logic        mosi;
  logic [23:0] hdr_sr;
  logic [7:0]  rx_sr;
  logic [7:0]  rx_byte;
  logic        byte_full;
  logic [4:0]  bit_cnt;
  logic [8:0]  rem;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        clr_hold;

  logic        gen_en;
  logic        gen_clr;
  logic        sck_rise;
  logic        sck_fall;
  logic        out_free;

  // In STALL the generator runs only to finish a high phase, so SCK parks low.
  assign gen_en  = (state == CS_SETUP) || (state == HEADER) || (state == DATA) ||
                   (state == CS_HOLD)  || ((state == STALL) && sck);
  assign gen_clr = (state == IDLE) || clr_hold;
  assign out_free = !rd_valid || RD_Ready;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .en       (gen_en),
    .clr      (gen_clr),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      pending   <= 1'b0;
      busy      <= 1'b0;
      cs_n      <= 1'b1;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      hdr_sr    <= '0;
      rx_sr     <= '0;
      rx_byte   <= '0;
      byte_full <= 1'b0;
      bit_cnt   <= '0;
      rem       <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      clr_hold  <= 1'b0;
    end else begin
      clr_hold <= 1'b0;

      // A completed byte moves out whenever the output slot is free or being
      // emptied this cycle, so back-to-back bytes keep RD_Valid high.
      if (byte_full && out_free) begin
        rd_data   <= rx_byte;
        rd_valid  <= 1'b1;
        byte_full <= 1'b0;
      end else if (rd_valid && RD_Ready) begin
        rd_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pending) begin
            pending <= 1'b0;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            mosi    <= hdr_sr[23];
            hdr_sr  <= {hdr_sr[22:0], 1'b0};
            bit_cnt <= '0;
            state   <= CS_SETUP;
          end else if (Start) begin
            pending <= 1'b1;
            hdr_sr  <= {READ_CMD, Addr};
            rem     <= burst_len(Len);
          end
        end

        CS_SETUP: begin
          // The end of the setup half-period is the first SCK rise.
          if (sck_rise) begin
            sck     <= 1'b1;
            bit_cnt <= 5'd1;
            state   <= HEADER;
          end
        end

        HEADER: begin
          if (sck_rise) begin
            sck     <= 1'b1;
            bit_cnt <= bit_cnt + 5'd1;
          end else if (sck_fall) begin
            sck <= 1'b0;
            if (bit_cnt == 5'(HDR_BITS)) begin
              mosi    <= 1'b0;
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              mosi   <= hdr_sr[23];
              hdr_sr <= {hdr_sr[22:0], 1'b0};
            end
          end
        end

        DATA: begin
          if (sck_rise) begin
            sck <= 1'b1;
            if (bit_cnt == 5'(BYTE_BITS - 1)) begin
              rx_byte   <= {rx_sr[6:0], SPI_MISO};
              byte_full <= 1'b1;
              bit_cnt   <= '0;
              rem       <= rem - 9'd1;
            end else begin
              rx_sr   <= {rx_sr[6:0], SPI_MISO};
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else if (sck_fall) begin
            sck <= 1'b0;
            if ((rem == 9'd0) && (bit_cnt == 5'd0)) begin
              clr_hold <= 1'b1;
              state    <= CS_HOLD;
            end
          end else if (byte_full && !out_free && (rem != 9'd0)) begin
            // The final byte never stalls: it just waits in rx_byte while CS closes.
            state <= STALL;
          end
        end

        STALL: begin
          if (sck_fall) begin
            sck <= 1'b0;
          end
          if (rd_valid && RD_Ready) begin
            state <= DATA;
          end
        end

        CS_HOLD: begin
          if (sck_rise || sck_fall) begin
            if (!cs_n) begin
              cs_n <= 1'b1;
            end else if (!rd_valid && !byte_full) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (!rd_valid && !byte_full) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign Busy     = busy;
  assign RD_Data  = rd_data;
  assign RD_Valid = rd_valid;
  assign SPI_SCK  = sck;
  assign SPI_CS_N = cs_n;
  assign SPI_MOSI = mosi;

endmodule
